// File: rtl/nbit_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, start/done handshake.
// Optional DIVIDER_DBZ_EN adds a div_by_zero flag and a one-cycle divide-by-zero path.
module nbit_divider #(
   parameter int unsigned DIVIDEND = 3,
   parameter int unsigned DIVISOR  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [DIVIDEND-1:0] dividend_i,
   input  logic [DIVISOR-1:0]  divisor_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [DIVIDEND-1:0] quotient_o,
`ifdef DIVIDER_DBZ_EN
   output logic                div_by_zero_o,
`endif
   output logic [DIVISOR-1:0]  remainder_o
);

   localparam int unsigned CntW = $clog2(DIVIDEND + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [DIVIDEND-1:0] dvd_q, dvd_d;
   logic [DIVISOR-1:0]  dvs_q, dvs_d;
   logic [DIVISOR-1:0]  rem_q, rem_d;
   logic [DIVIDEND-1:0] quotient_q, quotient_d;
   logic [DIVISOR-1:0]  remainder_q, remainder_d;
`ifdef DIVIDER_DBZ_EN
   logic                dbz_q, dbz_d;
`endif

   logic [DIVISOR:0]    shifted;
   logic                ge;
   logic [DIVISOR-1:0]  rem_next;
   logic [DIVIDEND-1:0] dvd_next;

   // dvd_q shifts left each step: dividend bits leave at the top, quotient bits enter at the bottom
   always_comb begin
      shifted  = {rem_q, dvd_q[DIVIDEND-1]};
      ge       = (shifted >= {1'b0, dvs_q});
      rem_next = ge ? DIVISOR'(shifted - {1'b0, dvs_q}) : shifted[DIVISOR-1:0];
      dvd_next = DIVIDEND'({dvd_q, ge});
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef DIVIDER_DBZ_EN
      dbz_d       = dbz_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               dvd_d   = dividend_i;
               dvs_d   = divisor_i;
               rem_d   = '0;
               cnt_d   = CntW'(DIVIDEND);
               state_d = StRun;
`ifdef DIVIDER_DBZ_EN
               dbz_d   = 1'b0;
               if (divisor_i == '0) begin
                  quotient_d  = '1;
                  remainder_d = DIVISOR'(dividend_i);
                  dbz_d       = 1'b1;
                  state_d     = StDone;
               end
`endif
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            dvd_d = dvd_next;
            rem_d = rem_next;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               quotient_d  = dvd_next;
               remainder_d = rem_next;
               state_d     = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIVIDER_DBZ_EN
         dbz_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
`ifdef DIVIDER_DBZ_EN
         dbz_q       <= dbz_d;
`endif
      end
   end

   assign busy_o      = (state_q == StRun);
   assign done_o      = (state_q == StDone);
   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;
`ifdef DIVIDER_DBZ_EN
   assign div_by_zero_o = dbz_q;
`endif

endmodule

// File: tb/tb_nbit_divider.sv
// Self-checking bench for nbit_divider: directed steps plus $urandom operands against
// an arithmetic reference model (floor division and modulo).
module tb_nbit_divider;

   localparam int DW = 3;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [SW-1:0] divisor = '0;
   logic          busy, done;
   logic [DW-1:0] quotient;
   logic [SW-1:0] remainder;
`ifdef DIVIDER_DBZ_EN
   logic          dbz;
`endif

   int checks = 0;
   int errors = 0;

   nbit_divider #(
      .DIVIDEND(DW),
      .DIVISOR (SW)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .busy_o       (busy),
      .done_o       (done),
      .quotient_o   (quotient),
`ifdef DIVIDER_DBZ_EN
      .div_by_zero_o(dbz),
`endif
      .remainder_o  (remainder)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_q(input int a, input int b);
      if (b == 0) return (1 << DW) - 1;
      return a / b;
   endfunction

   function automatic int ref_r(input int a, input int b);
      if (b == 0) return a % (1 << SW);
      return a - ref_q(a, b) * b;
   endfunction

   function automatic int ref_lat(input int b);
`ifdef DIVIDER_DBZ_EN
      if (b == 0) return 1;
`endif
      return DW + 1;
   endfunction

   // lat counts clock edges from the start-accepting edge (1) up to the edge that shows done
   task automatic run_op(input int a, input int b, output int lat, output int busy_cyc,
                         output int overlap);
      @(negedge clk);
      start    = 1'b1;
      dividend = DW'(a);
      divisor  = SW'(b);
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cyc = 0;
      overlap  = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_cyc++;
         if (busy === 1'b1 && done === 1'b1) overlap++;
         @(negedge clk);
         lat++;
      end
      if (busy === 1'b1 && done === 1'b1) overlap++;
   endtask

   task automatic check_op(input int a, input int b);
      int lat, bc, ov;
      run_op(a, b, lat, bc, ov);
      chk($sformatf("latency %0d/%0d", a, b), 32'(lat), 32'(ref_lat(b)));
      chk($sformatf("quotient %0d/%0d", a, b), 32'(quotient), 32'(ref_q(a, b)));
      chk($sformatf("remainder %0d/%0d", a, b), 32'(remainder), 32'(ref_r(a, b)));
      chk($sformatf("busy&done %0d/%0d", a, b), 32'(ov), 32'd0);
`ifdef DIVIDER_DBZ_EN
      chk($sformatf("div_by_zero %0d/%0d", a, b), 32'(dbz), 32'(b == 0));
`endif
   endtask

   initial begin
      int lat, bc, ov, seen, cyc, prev;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset quotient", 32'(quotient), 32'd0);
      chk("reset remainder", 32'(remainder), 32'd0);
`ifdef DIVIDER_DBZ_EN
      chk("reset div_by_zero", 32'(dbz), 32'd0);
`endif
      rst = 1'b0;

      // Basic 7/2 with busy duration
      run_op(7, 2, lat, bc, ov);
      chk("basic latency", 32'(lat), 32'(DW + 1));
      chk("basic busy cycles", 32'(bc), 32'(DW));
      chk("basic quotient", 32'(quotient), 32'd3);
      chk("basic remainder", 32'(remainder), 32'd1);
      @(negedge clk);
      chk("done single pulse", 32'(done), 32'd0);
      chk("quotient held", 32'(quotient), 32'd3);
      chk("remainder held", 32'(remainder), 32'd1);

      // Exhaustive sweep including divisor 0
      for (int b = 0; b < (1 << SW); b++)
         for (int a = 0; a < (1 << DW); a++)
            check_op(a, b);

      // Divide by zero, dividend 5
      check_op(5, 0);
      chk("dbz quotient all ones", 32'(quotient), 32'd7);
      chk("dbz remainder truncated", 32'(remainder), 32'd1);

      // Random operands
      for (int i = 0; i < 20; i++)
         check_op(int'($urandom_range((1 << DW) - 1, 0)), int'($urandom_range((1 << SW) - 1, 0)));

      // start during RUN is ignored
      @(negedge clk);
      start = 1'b1; dividend = 3'd7; divisor = 2'd2;
      @(negedge clk);
      lat = 1;
      dividend = 3'd5; divisor = 2'd1;
      @(negedge clk);
      lat++;
      start = 1'b0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("ignore latency", 32'(lat), 32'(DW + 1));
      chk("ignore quotient", 32'(quotient), 32'd3);
      chk("ignore remainder", 32'(remainder), 32'd1);

      // Reset in the middle of RUN aborts
      @(negedge clk);
      start = 1'b1; dividend = 3'd6; divisor = 2'd1;
      @(negedge clk);
      start = 1'b0;
      chk("abort in run", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort quotient", 32'(quotient), 32'd0);
      chk("abort remainder", 32'(remainder), 32'd0);
      seen = 0;
      repeat (2 * DW + 2) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      chk("abort no done", 32'(seen), 32'd0);
      check_op(5, 3);

      // start held high: back-to-back results
      @(negedge clk);
      start = 1'b1; dividend = 3'd6; divisor = 2'd2;
      cyc  = 0;
      prev = -1;
      for (int p = 0; p < 3; p++) begin
         while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("b2b quotient %0d", p), 32'(quotient), 32'd3);
         chk($sformatf("b2b remainder %0d", p), 32'(remainder), 32'd0);
         if (p == 0) chk("b2b first latency", 32'(cyc), 32'(DW + 1));
         else chk($sformatf("b2b spacing %0d", p), 32'(cyc - prev), 32'(DW + 1));
         prev = cyc;
         @(negedge clk);
         cyc++;
         chk($sformatf("b2b pulse width %0d", p), 32'(done), 32'd0);
      end
      start = 1'b0;
      repeat (DW + 2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
